// File: rtl/imem_loader.sv
// Program loader: length-prefixed big-endian byte stream -> imem word writes; holds the CPU in reset until done.
// Optional macro CHECKSUM_EN appends an XOR checksum byte that must match before the load is accepted.
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_imem_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_imem_wdata;
    logic                  r_cpu_reset;
    logic                  r_done;
    logic                  r_error;
    logic [15:0]           r_len;
    logic [15:0]           r_word_cnt;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_word;
`ifdef CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic        w_xfer;
    logic        w_start_ok;
    logic        w_last_word;
    logic [15:0] w_len;
    logic [31:0] w_word;

    assign w_xfer      = in_valid && r_in_ready;
    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign w_len       = {r_len[15:8], in_data};
    assign w_word      = {r_word, in_data};
    assign w_last_word = (r_word_cnt == r_len - 16'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_len        <= '0;
            r_word_cnt   <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
`ifdef CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_imem_we <= 1'b0;
            if (w_start_ok) begin
                r_state     <= S_LEN_HI;
                r_in_ready  <= 1'b1;
                r_done      <= 1'b0;
                r_error     <= 1'b0;
                r_cpu_reset <= 1'b1;
                r_word_cnt  <= '0;
                r_byte_idx  <= '0;
`ifdef CHECKSUM_EN
                r_csum      <= '0;
`endif
            end else begin
                case (r_state)
                    S_LEN_HI: if (w_xfer) begin
                        r_len[15:8] <= in_data;
                        r_state     <= S_LEN_LO;
                    end
                    S_LEN_LO: if (w_xfer) begin
                        r_len <= w_len;
                        if (w_len == 16'd0) begin
`ifdef CHECKSUM_EN
                            r_state    <= S_CSUM;
`else
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
`endif
                        end else if ({1'b0, w_len} > CAPACITY) begin
                            r_state    <= S_ERROR;
                            r_in_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    S_DATA: if (w_xfer) begin
                        r_word     <= w_word[23:0];
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef CHECKSUM_EN
                        r_csum     <= r_csum ^ in_data;
`endif
                        // Fourth byte completes a word: issue the write one cycle after this handshake.
                        if (r_byte_idx == 2'd3) begin
                            r_imem_we    <= 1'b1;
                            r_imem_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
                            r_imem_wdata <= w_word;
                            r_word_cnt   <= r_word_cnt + 16'd1;
                            if (w_last_word) begin
`ifdef CHECKSUM_EN
                                r_state    <= S_CSUM;
`else
                                r_state    <= S_DONE;
                                r_in_ready <= 1'b0;
`endif
                            end
                        end
                    end
`ifdef CHECKSUM_EN
                    S_CSUM: if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        if (in_data == r_csum) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                    end
`endif
                    S_DONE: begin
                        r_done      <= 1'b1;
                        r_cpu_reset <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_imem_we;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = r_imem_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: streams built from word lists, writes and final flags checked against a memory model.
module tb_imem_loader;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, imem_we, cpu_reset, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    int          n_checks = 0;
    int          n_errs = 0;
    wr_t         got_wr[$];
    int          hs_edges[$];
    logic [7:0]  stream[$];
    logic [7:0]  stream_x;
    logic [31:0] dut_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        prev_we, prev_done, prev_err, prev_cr;
    int          done_rise, err_rise, cr_fall;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: advance to the falling edge, then log whatever the DUT shows.
    task automatic tick();
        @(negedge clk);
        if (imem_we) begin
            chk("we_b2b", {31'b0, prev_we}, 32'd0);
            got_wr.push_back('{cyc, imem_addr, imem_wdata});
            dut_mem[imem_addr] = imem_wdata;
        end
        if (done === 1'b1 && prev_done !== 1'b1) done_rise = cyc;
        if (error === 1'b1 && prev_err !== 1'b1) err_rise = cyc;
        if (cpu_reset === 1'b0 && prev_cr === 1'b1) cr_fall = cyc;
        prev_we   = imem_we;
        prev_done = done;
        prev_err  = error;
        prev_cr   = cpu_reset;
    endtask

    task automatic do_start();
        got_wr.delete();
        hs_edges.delete();
        done_rise = -1;
        err_rise  = -1;
        cr_fall   = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: valid always high, 1: toggles 1/0, 2: random gaps
    task automatic feed(input logic [7:0] b[$], input int mode);
        int idx = 0;
        int guard = 0;
        bit ph = 1'b1;
        while (idx < b.size() && guard < 5000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ph;
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            ph = !ph;
            in_data = in_valid ? b[idx] : 8'($urandom);
            if (in_valid && in_ready) begin
                hs_edges.push_back(cyc + 1);
                idx++;
            end
            tick();
            guard++;
        end
        if (idx < b.size()) chk("feed_timeout", idx, b.size());
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic build(input logic [31:0] w[$]);
        stream.delete();
        stream_x = 8'h00;
        stream.push_back(8'(w.size() >> 8));
        stream.push_back(8'(w.size()));
        foreach (w[i]) begin
            for (int k = 3; k >= 0; k--) begin
                stream.push_back(w[i][8*k +: 8]);
                stream_x ^= w[i][8*k +: 8];
            end
        end
    endtask

    task automatic check_writes(input logic [31:0] w[$], input string tag);
        chk({tag, "_nwr"}, got_wr.size(), w.size());
        for (int i = 0; i < got_wr.size() && i < w.size(); i++) begin
            chk({tag, "_addr"}, {26'b0, got_wr[i].a}, i);
            chk({tag, "_data"}, got_wr[i].d, w[i]);
            chk({tag, "_lat"}, got_wr[i].c, hs_edges[4*i + 5]);
        end
    endtask

    task automatic run_ok(input logic [31:0] w[$], input int mode, input string tag);
        build(w);
`ifdef CHECKSUM_EN
        stream.push_back(stream_x);
`endif
        do_start();
        chk({tag, "_rdy0"}, {31'b0, in_ready}, 32'd1);
        feed(stream, mode);
        repeat (4) tick();
        check_writes(w, tag);
        foreach (w[i]) ref_mem[i] = w[i];
        chk({tag, "_done_t"}, done_rise, hs_edges[hs_edges.size() - 1] + 1);
        chk({tag, "_cpurst_t"}, cr_fall, hs_edges[hs_edges.size() - 1] + 1);
        chk({tag, "_flags"}, {28'b0, done, error, cpu_reset, in_ready}, 32'b1000);
    endtask

    task automatic run_err(input int n, input string tag);
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        do_start();
        feed(stream, 0);
        repeat (3) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
        chk({tag, "_nwr"}, got_wr.size(), 0);
        chk({tag, "_err_t"}, err_rise, hs_edges[1]);
        chk({tag, "_flags"}, {28'b0, done, error, cpu_reset, in_ready}, 32'b0110);
    endtask

    initial begin
        logic [31:0] w[$];
        logic [31:0] prog[$];
        for (int i = 0; i < DEPTH; i++) begin
            dut_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        prog = '{32'h20080005, 32'h2109FFFF};

        // Reset held low for two edges
        tick();
        tick();
        chk("rst_flags", {27'b0, done, error, cpu_reset, in_ready, imem_we}, 32'b00100);
        chk("rst_addr", {26'b0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        reset = 1'b1;
        tick();

        run_ok(prog, 0, "t2");
        run_ok(prog, 1, "t3");

        run_err(65, "t4");
        w.delete();
        run_ok(w, 0, "t4z");

        // Reset after five data bytes: one word written, then abort
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h21};
        do_start();
        feed(stream, 0);
        reset = 1'b0;
        tick();
        chk("t5_flags", {27'b0, done, error, cpu_reset, in_ready, imem_we}, 32'b00100);
        reset = 1'b1;
        repeat (5) tick();
        w = '{32'h20080005};
        check_writes(w, "t5");
        ref_mem[0] = 32'h20080005;
        run_ok(prog, 2, "t5b");

`ifdef CHECKSUM_EN
        // Wrong checksum byte: words still land, load rejected
        build(prog);
        stream.push_back((stream_x == 8'h1C) ? 8'h1D : 8'h1C);
        do_start();
        feed(stream, 0);
        repeat (4) tick();
        check_writes(prog, "t6");
        chk("t6_err_t", err_rise, hs_edges[hs_edges.size() - 1]);
        chk("t6_flags", {28'b0, done, error, cpu_reset, in_ready}, 32'b0110);
`endif

        for (int it = 0; it < 10; it++) begin
            if (it == 3) begin
                run_err(DEPTH + $urandom_range(1, 2000), "rnd_err");
            end else begin
                int n;
                n = (it == 5) ? DEPTH : (it == 7) ? 0 : $urandom_range(1, 8);
                w.delete();
                for (int i = 0; i < n; i++) w.push_back($urandom);
                run_ok(w, $urandom_range(0, 2), "rnd");
            end
        end

        for (int i = 0; i < DEPTH; i++) chk("mem", dut_mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
